relu_maxpool: RTL and testbench
===============================

RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 Parameter FILTER_SIZE, 15: number of feature maps on the input bus.
REQ-002 Parameter IN_BIT, 26: signed element width of the input maps.
REQ-003 Parameter FMAP_WIDTH, 27 and FMAP_HEIGHT, 27: input feature-map dimensions.
REQ-004 Parameter POOL, 2 and POOL_STRIDE, 2: square pooling window size and step.
REQ-005 Parameter POOL_WIDTH, (FMAP_WIDTH-POOL)/POOL_STRIDE+1 and POOL_HEIGHT, (FMAP_HEIGHT-POOL)/POOL_STRIDE+1: pooled map dimensions.
REQ-006 Parameter SHIFT, 8: arithmetic right-shift applied before requantisation.
REQ-007 Parameter OUT_BIT, 9: signed output element width, equal to the next layer's BIT_SIZE.
REQ-008 clock  input  1: single clock; all state updates on the rising edge.
REQ-009 reset  input  1: asynchronous, active-high reset.
REQ-010 enable  input  1: start, or continue, processing; low stalls the block.
REQ-011 filter_result  input  FILTER_SIZE*IN_BIT*FMAP_WIDTH*FMAP_HEIGHT: element (f,y,x) sits at index (f*FMAP_HEIGHT+y)*FMAP_WIDTH+x, IN_BIT wide, two's complement.
REQ-012 pool_result  output  FILTER_SIZE*OUT_BIT*POOL_WIDTH*POOL_HEIGHT: element (f,r,c) sits at index (f*POOL_HEIGHT+r)*POOL_WIDTH+c, registered.
REQ-013 done  output  1: registered; high when all pooled elements are valid.

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-015 IDLE with enable=1 at an edge: latch filter_result into an internal capture buffer, clear all counters and enter SCAN; the input bus is ignored thereafter.
REQ-016 SCAN with enable=1: each edge consumes one element, with nested counters f (outermost), r, c, ky, kx (innermost); element read = (f, r*POOL_STRIDE+ky, c*POOL_STRIDE+kx).
REQ-017 At ky=kx=0 the running max is loaded with the element; otherwise it becomes the signed max of itself and the element.
REQ-018 At ky=kx=POOL-1 the edge writes pool_result(f,r,c) = clamp(max(m,0)>>>SHIFT, 0, 2^(OUT_BIT-1)-1), where m is the final window max.
REQ-019 On the edge consuming the last element of the last window: enter DONE and set done=1.
REQ-020 Latency: done rises exactly 1+FILTER_SIZE*POOL_HEIGHT*POOL_WIDTH*POOL*POOL enabled edges after the start edge (10141 at defaults).
REQ-021 SCAN with enable=0: counters, running max and outputs SHALL hold; the elapsed stall cycles are added to the latency.
REQ-022 DONE: done and pool_result are sticky regardless of enable; only reset leaves DONE.
REQ-023 Windows SHALL never read outside the map; trailing rows/columns not covered by any window are ignored.

Reset
REQ-024 reset high SHALL immediately force state=IDLE, done=0, pool_result=0, and clear counters, running max and capture buffer, including when asserted mid-SCAN or in DONE.
REQ-025 After reset deasserts, the block SHALL wait in IDLE for enable=1.

Structure
REQ-026 Shared package cnn_pkg SHALL hold the width and size constants and the FSM state encoding; defaults SHALL match the filter stage (IN_BIT = SUBKERNEL_OUT_BIT + CHANNEL_EXTENSION_BIT).
REQ-027 One sub-module, relu_quant (combinational ReLU, shift and clamp, IN_BIT to OUT_BIT), SHALL be instantiated once.

Verification (F=2, FMAP 4x4, POOL=2, stride 2, IN_BIT=26, OUT_BIT=9, SHIFT=4)
REQ-028 Window f0(0,0) = {-5,100,32,7} with enable held -> pool_result(0,0,0)=6; done rises at edge 33 after the start edge.
REQ-029 Window all negative {-1,-300,-7,-2} -> that output = 0.
REQ-030 Window max 100000 -> output saturates to 255; value 4095 -> output 255; value 4079 -> output 254.
REQ-031 enable low for 5 cycles at edge 10 of SCAN -> done at edge 38, outputs identical to the unstalled run.
REQ-032 reset pulsed at edge 12 of SCAN -> done=0 and pool_result=0 before the next edge; a restart completes 33 edges after the new start.
REQ-033 filter_result changed after the start edge and enable toggled in DONE -> outputs reflect the captured data and done stays 1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN pipeline: element widths, map sizes and the
// pooling FSM state encoding.
package cnn_pkg;

    localparam int DEF_SUBKERNEL_OUT_BIT     = 22;
    localparam int DEF_CHANNEL_EXTENSION_BIT = 4;
    localparam int DEF_FILTER_SIZE           = 15;
    localparam int DEF_IN_BIT                = DEF_SUBKERNEL_OUT_BIT + DEF_CHANNEL_EXTENSION_BIT;
    localparam int DEF_FMAP_WIDTH            = 27;
    localparam int DEF_FMAP_HEIGHT           = 27;
    localparam int DEF_POOL                  = 2;
    localparam int DEF_POOL_STRIDE           = 2;
    localparam int DEF_SHIFT                 = 8;
    localparam int DEF_OUT_BIT               = 9;

    // Scan counters share one width; wide enough for any realistic map.
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } pool_state_t;

endpackage

// File: rtl/relu_quant.sv
// Combinational ReLU, arithmetic right shift and saturation to a positive
// signed OUT_BIT value.
module relu_quant #(
    parameter int IN_BIT  = 26,
    parameter int OUT_BIT = 9,
    parameter int SHIFT   = 8
) (
    input  logic signed [IN_BIT-1:0]  din,
    output logic        [OUT_BIT-1:0] dout
);

    localparam logic [OUT_BIT-1:0] OUT_MAX = {1'b0, {(OUT_BIT-1){1'b1}}};

    logic signed [IN_BIT-1:0] relu;
    logic        [IN_BIT-1:0] shifted;
    logic                     sat;

    always_comb begin
        relu    = din[IN_BIT-1] ? '0 : din;
        shifted = relu >>> SHIFT;
        sat     = shifted > {{(IN_BIT-OUT_BIT){1'b0}}, OUT_MAX};
        dout    = sat ? OUT_MAX : shifted[OUT_BIT-1:0];
    end

endmodule

// File: rtl/relu_maxpool.sv
// Captures a stack of feature maps, max-pools every window one element per
// enabled cycle, and writes ReLU-quantised results into a sticky output bus.
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int FILTER_SIZE = DEF_FILTER_SIZE,
    parameter int IN_BIT      = DEF_IN_BIT,
    parameter int FMAP_WIDTH  = DEF_FMAP_WIDTH,
    parameter int FMAP_HEIGHT = DEF_FMAP_HEIGHT,
    parameter int POOL        = DEF_POOL,
    parameter int POOL_STRIDE = DEF_POOL_STRIDE,
    parameter int POOL_WIDTH  = (FMAP_WIDTH - POOL) / POOL_STRIDE + 1,
    parameter int POOL_HEIGHT = (FMAP_HEIGHT - POOL) / POOL_STRIDE + 1,
    parameter int SHIFT       = DEF_SHIFT,
    parameter int OUT_BIT     = DEF_OUT_BIT
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic                                                 enable,
    input  logic [FILTER_SIZE*IN_BIT*FMAP_WIDTH*FMAP_HEIGHT-1:0] filter_result,
    output logic [FILTER_SIZE*OUT_BIT*POOL_WIDTH*POOL_HEIGHT-1:0] pool_result,
    output logic                                                 done,
    output pool_state_t                                          state_dbg
);

    localparam int IN_W  = FILTER_SIZE * IN_BIT * FMAP_WIDTH * FMAP_HEIGHT;
    localparam int OUT_W = FILTER_SIZE * OUT_BIT * POOL_WIDTH * POOL_HEIGHT;

    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FILTER_SIZE - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(POOL_HEIGHT - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(POOL_WIDTH - 1);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(POOL - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    pool_state_t state_q, state_d;
    logic [IN_W-1:0]  buf_q, buf_d;
    logic [OUT_W-1:0] pool_q, pool_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] f_q, f_d, r_q, r_d, c_q, c_d, ky_q, ky_d, kx_q, kx_d;
    logic signed [IN_BIT-1:0] max_q, max_d;

    logic signed [IN_BIT-1:0] elem;
    logic signed [IN_BIT-1:0] cur_max;
    logic        [OUT_BIT-1:0] q_out;
    logic win_first, win_last;
    int   y_idx, x_idx, elem_idx, out_idx;

    // Window element addressing and running max; kept apart from the state
    // update so the quantiser path is not seen as a loop.
    always_comb begin
        y_idx     = int'(r_q) * POOL_STRIDE + int'(ky_q);
        x_idx     = int'(c_q) * POOL_STRIDE + int'(kx_q);
        elem_idx  = (int'(f_q) * FMAP_HEIGHT + y_idx) * FMAP_WIDTH + x_idx;
        out_idx   = (int'(f_q) * POOL_HEIGHT + int'(r_q)) * POOL_WIDTH + int'(c_q);
        elem      = buf_q[elem_idx*IN_BIT +: IN_BIT];
        win_first = (ky_q == '0) && (kx_q == '0);
        win_last  = (ky_q == K_LAST) && (kx_q == K_LAST);
        if (win_first || (elem > max_q)) begin
            cur_max = elem;
        end else begin
            cur_max = max_q;
        end
    end

    relu_quant #(
        .IN_BIT (IN_BIT),
        .OUT_BIT(OUT_BIT),
        .SHIFT  (SHIFT)
    ) u_relu_quant (
        .din (cur_max),
        .dout(q_out)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pool_d  = pool_q;
        done_d  = done_q;
        f_d     = f_q;
        r_d     = r_q;
        c_d     = c_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        max_d   = max_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    buf_d   = filter_result;
                    f_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                    max_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (enable) begin
                    max_d = cur_max;
                    if (win_last) begin
                        pool_d[out_idx*OUT_BIT +: OUT_BIT] = q_out;
                    end
                    // Odometer advance: kx innermost, f outermost.
                    if (kx_q != K_LAST) begin
                        kx_d = kx_q + ONE;
                    end else begin
                        kx_d = '0;
                        if (ky_q != K_LAST) begin
                            ky_d = ky_q + ONE;
                        end else begin
                            ky_d = '0;
                            if (c_q != C_LAST) begin
                                c_d = c_q + ONE;
                            end else begin
                                c_d = '0;
                                if (r_q != R_LAST) begin
                                    r_d = r_q + ONE;
                                end else begin
                                    r_d = '0;
                                    if (f_q != F_LAST) begin
                                        f_d = f_q + ONE;
                                    end else begin
                                        state_d = DONE;
                                        done_d  = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            pool_q  <= '0;
            done_q  <= 1'b0;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pool_q  <= pool_d;
            done_q  <= done_d;
            f_q     <= f_d;
            r_q     <= r_d;
            c_q     <= c_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            max_q   <= max_d;
        end
    end

    assign pool_result = pool_q;
    assign done        = done_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool on a small 2 x 4x4 configuration.
module tb_relu_maxpool;
    import cnn_pkg::*;

    localparam int F     = 2;
    localparam int H     = 4;
    localparam int W     = 4;
    localparam int IN    = 26;
    localparam int OUT   = 9;
    localparam int SH    = 4;
    localparam int PH    = 2;
    localparam int PW    = 2;
    localparam int FR_W  = F * IN * W * H;
    localparam int PR_W  = F * OUT * PW * PH;
    localparam int LAT   = 1 + F * PH * PW * 4;
    localparam int BOUND = 200;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [FR_W-1:0]   filter_result;
    logic [PR_W-1:0]   pool_result;
    logic              done;
    pool_state_t       state_dbg;

    int fm [F][H][W];
    logic [OUT-1:0] exp_q [$];
    int assert_cnt = 0;
    int fail_cnt   = 0;
    int edges;

    relu_maxpool #(
        .FILTER_SIZE(F), .IN_BIT(IN), .FMAP_WIDTH(W), .FMAP_HEIGHT(H),
        .POOL(2), .POOL_STRIDE(2), .SHIFT(SH), .OUT_BIT(OUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .filter_result(filter_result),
        .pool_result  (pool_result),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assert_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [OUT-1:0] pool_el(input int f, input int r, input int c);
        return pool_result[((f*PH + r)*PW + c)*OUT +: OUT];
    endfunction

    task automatic load_fmap();
        for (int f = 0; f < F; f++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    filter_result[((f*H + y)*W + x)*IN +: IN] = IN'(fm[f][y][x]);
    endtask

    task automatic scramble_bus();
        for (int i = 0; i < FR_W; i += 32) filter_result[i +: 32] = $urandom;
    endtask

    function automatic logic [OUT-1:0] model_win(input int f, input int r, input int c);
        int m;
        m = fm[f][2*r][2*c];
        for (int ky = 0; ky < 2; ky++)
            for (int kx = 0; kx < 2; kx++)
                if (fm[f][2*r+ky][2*c+kx] > m) m = fm[f][2*r+ky][2*c+kx];
        if (m < 0) m = 0;
        m = m / (1 << SH);
        if (m > 255) m = 255;
        return OUT'(m);
    endfunction

    task automatic push_expected();
        for (int f = 0; f < F; f++)
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++)
                    exp_q.push_back(model_win(f, r, c));
    endtask

    task automatic check_outputs(input string tag);
        logic [OUT-1:0] e;
        for (int f = 0; f < F; f++)
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++) begin
                    if (exp_q.size() == 0) begin
                        check({tag, "_queue_empty"}, 64'd0, 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("%s_f%0d_r%0d_c%0d", tag, f, r, c), 64'(pool_el(f, r, c)), 64'(e));
                    end
                end
    endtask

    // Start on the next edge and count edges (start edge = 1) until done.
    task automatic run_scan(input int stall_at, input int stall_len, output int n);
        n = 0;
        enable = 1'b1;
        while (n < BOUND) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 1) scramble_bus();
            if (stall_at > 0 && n == stall_at) enable = 1'b0;
            if (stall_at > 0 && n == stall_at + stall_len) enable = 1'b1;
            if (done) break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        filter_result = '0;

        // Feature maps: small random background, then directed windows.
        for (int f = 0; f < F; f++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    fm[f][y][x] = int'($urandom_range(0, 9000)) - 5000;
        fm[0][0][0] = -5;   fm[0][0][1] = 100;  fm[0][1][0] = 32;  fm[0][1][1] = 7;
        fm[0][0][2] = -1;   fm[0][0][3] = -300; fm[0][1][2] = -7;  fm[0][1][3] = -2;
        fm[0][3][0] = 100000;
        fm[0][2][3] = 4095;
        fm[1][1][1] = 4079;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_done", 64'(done), 64'd0);
        check("rst_pool", 64'(pool_result == '0), 64'd1);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_wait", 64'(state_dbg), 64'(IDLE));

        // Unstalled run; bus scrambled after the start edge
        load_fmap();
        push_expected();
        run_scan(0, 0, edges);
        check("lat_run1", 64'(edges), 64'(LAT));
        check("w000_value", 64'(pool_el(0, 0, 0)), 64'd6);
        check("neg_window", 64'(pool_el(0, 0, 1)), 64'd0);
        check("sat_100000", 64'(pool_el(0, 1, 0)), 64'd255);
        check("sat_4095", 64'(pool_el(0, 1, 1)), 64'd255);
        check("val_4079", 64'(pool_el(1, 0, 0)), 64'd254);
        check_outputs("run1");

        // DONE is sticky across enable toggles and bus changes
        for (int i = 0; i < 6; i++) begin
            enable = i[0];
            scramble_bus();
            @(posedge clock);
            #1;
            check("done_sticky", 64'(done), 64'd1);
            check("state_done", 64'(state_dbg), 64'(DONE));
        end
        push_expected();
        check_outputs("sticky");

        // Reset in DONE
        #2 reset = 1'b1;
        #1;
        check("rst_in_done", 64'(done), 64'd0);
        check("rst_in_done_pool", 64'(pool_result == '0), 64'd1);
        do_reset();

        // Stalled run: 5 disabled edges after edge 10
        load_fmap();
        push_expected();
        run_scan(10, 5, edges);
        check("lat_stall", 64'(edges), 64'(LAT + 5));
        check_outputs("stall");

        // Reset mid-scan at edge 12
        do_reset();
        load_fmap();
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
        end
        check("mid_w000", 64'(pool_el(0, 0, 0)), 64'd6);
        check("mid_done_low", 64'(done), 64'd0);
        enable = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("abort_done", 64'(done), 64'd0);
        check("abort_pool", 64'(pool_result == '0), 64'd1);
        check("abort_state", 64'(state_dbg), 64'(IDLE));
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_abort_idle", 64'(state_dbg), 64'(IDLE));
        load_fmap();
        push_expected();
        run_scan(0, 0, edges);
        check("lat_restart", 64'(edges), 64'(LAT));
        check_outputs("restart");
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
